ibex_efpga_sched: RTL

- Scheduler/arbiter that shares the single eFPGA accelerator between NUM_REQ requesters, e.g. the ID/EX stage and a debug/DMA port.
- Accepts one operation per grant using round-robin priority. It drives the accelerator's enable, operator and delay inputs, waits for the one-cycle ready pulse, and returns the captured result to the granted requester.
- A watchdog reports an error if the accelerator does not answer within TIMEOUT cycles.

---
 rtl/ibex_efpga_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ibex_efpga_sched.sv
`default_nettype none
// ============================================================================
//  Module   : ibex_efpga_sched
//  Purpose  : Round-robin scheduler that shares one eFPGA accelerator between
//             NUM_REQ requesters. It issues one operation per grant, waits
//             for the accelerator's ready pulse under a watchdog, and returns
//             the result or a timeout error to the granted requester.
//  Revision : 1.0 - initial release
// ============================================================================
module ibex_efpga_sched #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [2*NUM_REQ-1:0]   req_op_i,
  input  logic [4*NUM_REQ-1:0]   req_delay_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [31:0]            rsp_data_o,
  output logic                   rsp_err_o,
  output logic                   busy_o,
  output logic                   efpga_en_o,
  output logic [1:0]             efpga_operator_o,
  output logic [3:0]             efpga_delay_o,
  input  logic                   efpga_ready_i,
  input  logic [31:0]            efpga_result_i
);

  localparam int c_IDX_W = $clog2(NUM_REQ);
  localparam int c_SUM_W = c_IDX_W + 1;
  localparam int c_CNT_W = $clog2(TIMEOUT);
  localparam logic [c_IDX_W-1:0] c_LAST_RST = c_IDX_W'(NUM_REQ - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_last;
  logic [c_IDX_W-1:0]   r_owner;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_found;
  logic [c_IDX_W-1:0]   w_winner;
  logic [c_SUM_W-1:0]   w_idx;
  logic [NUM_REQ-1:0]   w_gnt;
  logic [1:0]           w_op;
  logic [3:0]           w_dly;

  // Round-robin search: first requester found starting just above the last winner.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = {1'b0, r_last} + c_SUM_W'(k);
      if (w_idx >= c_SUM_W'(NUM_REQ)) begin
        w_idx = w_idx - c_SUM_W'(NUM_REQ);
      end
      if (!w_found && req_i[w_idx[c_IDX_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[c_IDX_W-1:0];
      end
    end
  end

  // Grant is combinational in the IDLE cycle; suppressed while reset is asserted.
  always_comb begin
    w_gnt = '0;
    if (rst_n && (r_state == S_IDLE) && w_found) begin
      w_gnt[w_winner] = 1'b1;
    end
  end

  assign gnt_o  = w_gnt;
  assign busy_o = (r_state != S_IDLE);
  assign w_op   = req_op_i[{w_winner, 1'b0} +: 2];
  assign w_dly  = req_delay_i[{w_winner, 2'b00} +: 4];

  // Transaction FSM with registered accelerator and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_last           <= c_LAST_RST;
      r_owner          <= '0;
      r_cnt            <= '0;
      rsp_valid_o      <= '0;
      rsp_data_o       <= '0;
      rsp_err_o        <= 1'b0;
      efpga_en_o       <= 1'b0;
      efpga_operator_o <= '0;
      efpga_delay_o    <= '0;
    end else begin
      efpga_en_o  <= 1'b0;
      rsp_valid_o <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner          <= w_winner;
            r_last           <= w_winner;
            efpga_operator_o <= w_op;
            efpga_delay_o    <= w_dly;
            efpga_en_o       <= 1'b1;
            r_state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A ready arriving in the last watchdog cycle still counts as good.
          if (efpga_ready_i) begin
            rsp_data_o           <= efpga_result_i;
            rsp_err_o            <= 1'b0;
            rsp_valid_o[r_owner] <= 1'b1;
            r_state              <= S_RESP;
          end else if (r_cnt == c_CNT_MAX) begin
            rsp_data_o           <= '0;
            rsp_err_o            <= 1'b1;
            rsp_valid_o[r_owner] <= 1'b1;
            r_state              <= S_RESP;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        S_RESP: begin
          // After a timeout the late ready must be swallowed before reuse;
          // if it lands right here there is nothing left to drain.
          if (!rsp_err_o || efpga_ready_i) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (efpga_ready_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
